va_ovc_state_ctrl: RTL and testbench

//   Per-output-port output-VC state controller. Tracks ownership, credits and

---
 rtl/va_ovc_state_ctrl.sv | 125 ++++++++++++
 tb/tb_va_ovc_state_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/va_ovc_state_ctrl.sv
// ---------------------------------------------------------------------------
// va_ovc_state_ctrl
//   Output-VC state controller for one router output port. Tracks, for each
//   of the V downstream VCs, the ownership state (IDLE / ACTIVE / DRAIN), the
//   owning input VC, and the downstream credit count. Publishes per-VC
//   availability and credit flags to the VC allocator.
//
// Ports
//   clk            clock, rising edge
//   rstn           asynchronous active-low reset
//   vaGrant        [V]      VA grant per output VC
//   vaGrantOwner   [V*OW]   owner id (inPort*V + inVC) per granted VC
//   flitVld        flit leaves this output port
//   flitVC         [VW]     output VC of that flit
//   flitTail       that flit is a tail
//   creditVld      credit returned from downstream
//   creditVC       [VW]     VC of the returned credit
//   outVCAvailable [V]      1 = VC is IDLE
//   creditAvail    [V]      1 = credit count of that VC is non-zero
//   vcOwner        [V*OW]   registered owner id per VC
//   errFlag        sticky protocol-violation flag
// ---------------------------------------------------------------------------
module va_ovc_state_ctrl #(
  parameter int N         = 5,
  parameter int V         = 4,
  parameter int BUF_DEPTH = 4,
  localparam int OW = $clog2(N * V),
  localparam int VW = (V > 1) ? $clog2(V) : 1,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [V-1:0]    vaGrant,
  input  logic [V*OW-1:0] vaGrantOwner,
  input  logic            flitVld,
  input  logic [VW-1:0]   flitVC,
  input  logic            flitTail,
  input  logic            creditVld,
  input  logic [VW-1:0]   creditVC,
  output logic [V-1:0]    outVCAvailable,
  output logic [V-1:0]    creditAvail,
  output logic [V*OW-1:0] vcOwner,
  output logic            errFlag
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } vc_state_t;

  localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);

  logic [V-1:0] vc_err;

  genvar gi;
  generate
    for (gi = 0; gi < V; gi++) begin : g_vc
      vc_state_t     state_reg;
      logic [CW-1:0] count_reg;
      logic [CW-1:0] count_next;
      logic [OW-1:0] owner_reg;
      logic          flit_hit;
      logic          credit_hit;
      logic          flit_eff;
      logic          err_next;

      always_comb begin
        flit_hit   = flitVld && (flitVC == VW'(gi));
        credit_hit = creditVld && (creditVC == VW'(gi));
        // Only a flit on an ACTIVE VC consumes a credit; any other flit is
        // a protocol violation and is dropped entirely.
        flit_eff   = flit_hit && (state_reg == ST_ACTIVE);
        count_next = count_reg;
        err_next   = 1'b0;
        if (flit_eff && !credit_hit) begin
          if (count_reg == '0) err_next = 1'b1;
          else                 count_next = count_reg - CW'(1);
        end else if (credit_hit && !flit_eff) begin
          if (count_reg == CNT_FULL) err_next = 1'b1;
          else                       count_next = count_reg + CW'(1);
        end
        if (flit_hit && (state_reg != ST_ACTIVE)) err_next = 1'b1;
        if (vaGrant[gi] && (state_reg != ST_IDLE)) err_next = 1'b1;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          state_reg <= ST_IDLE;
          count_reg <= CNT_FULL;
          owner_reg <= '0;
        end else begin
          count_reg <= count_next;
          case (state_reg)
            ST_IDLE: begin
              if (vaGrant[gi]) begin
                state_reg <= ST_ACTIVE;
                owner_reg <= vaGrantOwner[gi*OW +: OW];
              end
            end
            ST_ACTIVE: begin
              if (flit_eff && flitTail) state_reg <= ST_DRAIN;
            end
            ST_DRAIN: begin
              // A credit landing this cycle already counts toward the drain.
              if (count_next == CNT_FULL) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
          endcase
        end
      end

      assign vc_err[gi]                = err_next;
      assign outVCAvailable[gi]        = (state_reg == ST_IDLE);
      assign creditAvail[gi]           = (count_reg != '0);
      assign vcOwner[gi*OW +: OW]      = owner_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        errFlag <= 1'b0;
    else if (|vc_err) errFlag <= 1'b1;
  end

endmodule

// File: tb/tb_va_ovc_state_ctrl.sv
module tb_va_ovc_state_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  vaGrant;
  logic [19:0] vaGrantOwner;
  logic        flitVld;
  logic [1:0]  flitVC;
  logic        flitTail;
  logic        creditVld;
  logic [1:0]  creditVC;
  logic [3:0]  outVCAvailable;
  logic [3:0]  creditAvail;
  logic [19:0] vcOwner;
  logic        errFlag;

  int errors = 0;
  int checks = 0;

  va_ovc_state_ctrl #(.N(5), .V(4), .BUF_DEPTH(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .vaGrant        (vaGrant),
    .vaGrantOwner   (vaGrantOwner),
    .flitVld        (flitVld),
    .flitVC         (flitVC),
    .flitTail       (flitTail),
    .creditVld      (creditVld),
    .creditVC       (creditVC),
    .outVCAvailable (outVCAvailable),
    .creditAvail    (creditAvail),
    .vcOwner        (vcOwner),
    .errFlag        (errFlag)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    vaGrant      = '0;
    vaGrantOwner = '0;
    flitVld      = 1'b0;
    flitVC       = '0;
    flitTail     = 1'b0;
    creditVld    = 1'b0;
    creditVC     = '0;
  endtask

  // Inputs set before step() are captured at the next rising edge; outputs
  // are then observed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_inputs();
    step();
    step();
    rstn = 1'b1;
    step();
    $display("reset applied and released");
  endtask

  task automatic grant(input logic [3:0] mask, input logic [19:0] owners);
    vaGrant      = mask;
    vaGrantOwner = owners;
    $display("grant mask=%b owners=%h", mask, owners);
    step();
  endtask

  task automatic flit(input int vc, input logic tail);
    flitVld  = 1'b1;
    flitVC   = vc[1:0];
    flitTail = tail;
    $display("flit vc=%0d tail=%0b", vc, tail);
    step();
  endtask

  task automatic credit(input int vc);
    creditVld = 1'b1;
    creditVC  = vc[1:0];
    $display("credit vc=%0d", vc);
    step();
  endtask

  task automatic flit_credit(input int vc);
    flitVld   = 1'b1;
    flitVC    = vc[1:0];
    creditVld = 1'b1;
    creditVC  = vc[1:0];
    $display("flit+credit vc=%0d", vc);
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    clear_inputs();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (outVCAvailable !== 4'hF) begin
      errors++; $display("FAIL reset_avail got=%h exp=%h", outVCAvailable, 4'hF);
    end
    checks++;
    if (creditAvail !== 4'hF) begin
      errors++; $display("FAIL reset_credit got=%h exp=%h", creditAvail, 4'hF);
    end
    checks++;
    if (vcOwner !== 20'h0) begin
      errors++; $display("FAIL reset_owner got=%h exp=%h", vcOwner, 20'h0);
    end
    checks++;
    if (errFlag !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b exp=0", errFlag);
    end
    step();
    rstn = 1'b1;
    step();
    step();
    $display("reset released");
    checks++;
    if (outVCAvailable !== 4'hF || creditAvail !== 4'hF || errFlag !== 1'b0) begin
      errors++;
      $display("FAIL post_reset avail=%h credit=%h err=%b exp F F 0",
               outVCAvailable, creditAvail, errFlag);
    end
  endtask

  task automatic test_alloc();
    grant(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0});
    checks++;
    if (outVCAvailable !== 4'b1011) begin
      errors++; $display("FAIL alloc_avail got=%b exp=1011", outVCAvailable);
    end
    checks++;
    if (vcOwner[10 +: 5] !== 5'd7) begin
      errors++; $display("FAIL alloc_owner got=%0d exp=7", vcOwner[10 +: 5]);
    end
    checks++;
    if (errFlag !== 1'b0) begin
      errors++; $display("FAIL alloc_err got=%b exp=0", errFlag);
    end
  endtask

  // Continues from test_alloc: VC2 ACTIVE, count 4.
  task automatic test_drain();
    for (int i = 0; i < 3; i++) begin
      flit(2, 1'b0);
      checks++;
      if (creditAvail !== 4'hF) begin
        errors++; $display("FAIL drain_body%0d credit got=%b exp=1111", i, creditAvail);
      end
    end
    flit(2, 1'b1);
    checks++;
    if (creditAvail !== 4'b1011) begin
      errors++; $display("FAIL drain_tail credit got=%b exp=1011", creditAvail);
    end
    checks++;
    if (outVCAvailable !== 4'b1011) begin
      errors++; $display("FAIL drain_tail avail got=%b exp=1011", outVCAvailable);
    end
    step();
    checks++;
    if (outVCAvailable !== 4'b1011) begin
      errors++; $display("FAIL drain_hold avail got=%b exp=1011", outVCAvailable);
    end
    for (int i = 1; i <= 4; i++) begin
      credit(2);
      checks++;
      if (i < 4 && (outVCAvailable !== 4'b1011 || creditAvail !== 4'hF)) begin
        errors++;
        $display("FAIL drain_credit%0d avail=%b credit=%b exp 1011 1111",
                 i, outVCAvailable, creditAvail);
      end else if (i == 4 && outVCAvailable !== 4'hF) begin
        errors++; $display("FAIL drain_final avail got=%b exp=1111", outVCAvailable);
      end
    end
    checks++;
    if (errFlag !== 1'b0) begin
      errors++; $display("FAIL drain_err got=%b exp=0", errFlag);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    grant(4'b0010, {5'd0, 5'd0, 5'd13, 5'd0});
    flit(1, 1'b0);
    flit(1, 1'b0);
    flit_credit(1);
    checks++;
    if (creditAvail !== 4'hF || errFlag !== 1'b0) begin
      errors++; $display("FAIL simul_fc credit=%b err=%b exp 1111 0", creditAvail, errFlag);
    end
    // Count must still be 2: one more flit leaves 1, the next leaves 0.
    flit(1, 1'b0);
    checks++;
    if (creditAvail !== 4'hF) begin
      errors++; $display("FAIL simul_cnt1 credit got=%b exp=1111", creditAvail);
    end
    flit(1, 1'b0);
    checks++;
    if (creditAvail !== 4'b1101) begin
      errors++; $display("FAIL simul_cnt0 credit got=%b exp=1101", creditAvail);
    end
    grant(4'b1001, {5'd18, 5'd0, 5'd0, 5'd5});
    checks++;
    if (outVCAvailable !== 4'b0100) begin
      errors++; $display("FAIL multi_grant avail got=%b exp=0100", outVCAvailable);
    end
    checks++;
    if (vcOwner !== {5'd18, 5'd0, 5'd13, 5'd5}) begin
      errors++; $display("FAIL multi_owner got=%h exp=%h", vcOwner, {5'd18, 5'd0, 5'd13, 5'd5});
    end
    checks++;
    if (errFlag !== 1'b0) begin
      errors++; $display("FAIL simul_err got=%b exp=0", errFlag);
    end
  endtask

  task automatic test_errors();
    // (a) flit to IDLE VC0
    apply_reset();
    flit(0, 1'b0);
    checks++;
    if (errFlag !== 1'b1 || creditAvail !== 4'hF || outVCAvailable !== 4'hF) begin
      errors++;
      $display("FAIL err_flit_idle err=%b credit=%b avail=%b exp 1 1111 1111",
               errFlag, creditAvail, outVCAvailable);
    end
    step();
    checks++;
    if (errFlag !== 1'b1) begin
      errors++; $display("FAIL err_sticky got=%b exp=1", errFlag);
    end
    grant(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3});
    checks++;
    if (outVCAvailable !== 4'b1110) begin
      errors++; $display("FAIL err_flit_idle_state avail got=%b exp=1110", outVCAvailable);
    end
    for (int i = 0; i < 3; i++) flit(0, 1'b0);
    checks++;
    if (creditAvail !== 4'hF) begin
      errors++; $display("FAIL err_flit_idle_cnt3 credit got=%b exp=1111", creditAvail);
    end
    flit(0, 1'b0);
    checks++;
    if (creditAvail !== 4'b1110) begin
      errors++; $display("FAIL err_flit_idle_cnt4 credit got=%b exp=1110", creditAvail);
    end

    // (b) credit to VC1 at full count
    apply_reset();
    credit(1);
    checks++;
    if (errFlag !== 1'b1 || creditAvail !== 4'hF) begin
      errors++; $display("FAIL err_credit_full err=%b credit=%b exp 1 1111", errFlag, creditAvail);
    end
    grant(4'b0010, {5'd0, 5'd0, 5'd4, 5'd0});
    for (int i = 0; i < 3; i++) flit(1, 1'b0);
    checks++;
    if (creditAvail !== 4'hF) begin
      errors++; $display("FAIL err_credit_cnt3 credit got=%b exp=1111", creditAvail);
    end
    flit(1, 1'b0);
    checks++;
    if (creditAvail !== 4'b1101) begin
      errors++; $display("FAIL err_credit_cnt4 credit got=%b exp=1101", creditAvail);
    end

    // (c) second grant to ACTIVE VC2
    apply_reset();
    grant(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0});
    checks++;
    if (errFlag !== 1'b0) begin
      errors++; $display("FAIL err_grant_pre err got=%b exp=0", errFlag);
    end
    grant(4'b0100, {5'd0, 5'd9, 5'd0, 5'd0});
    checks++;
    if (errFlag !== 1'b1 || vcOwner[10 +: 5] !== 5'd7 || outVCAvailable !== 4'b1011) begin
      errors++;
      $display("FAIL err_grant_active err=%b owner=%0d avail=%b exp 1 7 1011",
               errFlag, vcOwner[10 +: 5], outVCAvailable);
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    grant(4'b0100, {5'd0, 5'd11, 5'd0, 5'd0});
    for (int i = 0; i < 3; i++) flit(2, 1'b0);
    credit(0);
    checks++;
    if (outVCAvailable !== 4'b1011 || errFlag !== 1'b1 || vcOwner[10 +: 5] !== 5'd11) begin
      errors++;
      $display("FAIL midop_pre avail=%b err=%b owner=%0d exp 1011 1 11",
               outVCAvailable, errFlag, vcOwner[10 +: 5]);
    end
    #3 rstn = 1'b0;
    $display("async reset asserted mid-cycle");
    #1;
    checks++;
    if (outVCAvailable !== 4'hF || creditAvail !== 4'hF || vcOwner !== 20'h0 || errFlag !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset avail=%b credit=%b owner=%h err=%b exp 1111 1111 0 0",
               outVCAvailable, creditAvail, vcOwner, errFlag);
    end
    step();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_drain();
    test_simultaneous();
    test_errors();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
